// File: rtl/calc_key_latch_if.sv
// Bus between the DE2 pushbutton/switch front end and the calculator input stage.
// The master drives raw keys and switches; the slave presents latched op/a/b.
interface calc_key_latch_if #(
  parameter int W = 4
);
  logic [2:0]     key_n;
  logic [2*W-1:0] sw;
  logic [2:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           load;
  logic           valid;

  modport master (
    output key_n,
    output sw,
    input  op,
    input  a,
    input  b,
    input  load,
    input  valid
  );

  modport slave (
    input  key_n,
    input  sw,
    output op,
    output a,
    output b,
    output load,
    output valid
  );
endinterface

// File: rtl/calc_key_latch.sv
// Calculator input stage: synchronises and debounces KEY[2:0], merges chords into one
// opcode and latches the switch operands once per press event.
module calc_key_latch #(
  parameter int W               = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CHORD_CYCLES    = 1000000
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  calc_key_latch_if.slave  bus
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int CW = (CHORD_CYCLES > 1) ? $clog2(CHORD_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CH_LAST = CW'(CHORD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_WAIT_REL = 2'd2
  } state_t;

  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_stable;
  logic [2:0]    r_press;
  logic [DW-1:0] r_db_cnt [3];

  state_t        r_state;
  logic [2:0]    r_accum;
  logic [CW-1:0] r_timer;
  logic [2:0]    r_op;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_load;
  logic          r_valid;

  // Two-flop synchroniser for the asynchronous pushbuttons
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_sync1 <= 3'b111;
      r_sync2 <= 3'b111;
    end else begin
      r_sync1 <= bus.key_n;
      r_sync2 <= r_sync1;
    end
  end

  // Per-key debounce; the count only reaches DB_LAST, so it can never wrap
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_stable <= 3'b111;
      r_press  <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        r_db_cnt[i] <= {DW{1'b0}};
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_press[i] <= 1'b0;
        if (r_sync2[i] == r_stable[i]) begin
          r_db_cnt[i] <= {DW{1'b0}};
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_stable[i] <= r_sync2[i];
          r_db_cnt[i] <= {DW{1'b0}};
          r_press[i]  <= ~r_sync2[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Chord collection and operand capture
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_accum <= 3'b000;
      r_timer <= {CW{1'b0}};
      r_op    <= 3'b111;
      r_a     <= {W{1'b0}};
      r_b     <= {W{1'b0}};
      r_load  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_load <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|r_press) begin
            r_state <= ST_COLLECT;
            r_accum <= r_press;
            r_timer <= {CW{1'b0}};
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_COLLECT: begin
          r_accum <= r_accum | r_press;
          if (r_timer == CH_LAST) begin
            r_op    <= ~r_accum;
            r_a     <= bus.sw[2*W-1:W];
            r_b     <= bus.sw[W-1:0];
            r_load  <= 1'b1;
            r_valid <= 1'b1;
            r_state <= ST_WAIT_REL;
          end else begin
            r_timer <= r_timer + CW'(1);
          end
        end
        ST_WAIT_REL: begin
          if (r_stable == 3'b111) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_WAIT_REL;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.op    = r_op;
  assign bus.a     = r_a;
  assign bus.b     = r_b;
  assign bus.load  = r_load;
  assign bus.valid = r_valid;

endmodule

// File: tb/tb_calc_key_latch.sv
// Bench for calc_key_latch: directed key/switch sequences push expected captures into a
// queue, a negedge monitor pops and compares each load pulse.
module tb_calc_key_latch;

  localparam int W = 4;

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_errors;
  int   load_cnt;
  logic prev_load;
  exp_t exp_q [$];

  calc_key_latch_if #(.W(W)) bus ();

  calc_key_latch #(
    .W(W),
    .DEBOUNCE_CYCLES(4),
    .CHORD_CYCLES(8)
  ) dut (
    .CLOCK_50(clk),
    .resetn(resetn),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every load pulse must match the oldest expected capture
  always @(negedge clk) begin
    if (resetn && bus.load) begin
      check("load_not_consecutive", {31'd0, prev_load}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_load", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("op", {29'd0, bus.op}, {29'd0, e.op});
        check("a", {28'd0, bus.a}, {28'd0, e.a});
        check("b", {28'd0, bus.b}, {28'd0, e.b});
        check("valid", {31'd0, bus.valid}, 32'd1);
      end
      load_cnt++;
    end
    prev_load <= bus.load;
  end

  task automatic wait_loads(input int target, input int budget);
    int n;
    n = 0;
    while (load_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    if (load_cnt < target) begin
      check("load_timeout", 32'(load_cnt), 32'(target));
    end
  endtask

  task automatic release_all();
    @(posedge clk);
    #1 bus.key_n = 3'b111;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_op"}, {29'd0, bus.op}, 32'h7);
    check({tag, "_a"}, {28'd0, bus.a}, 32'h0);
    check({tag, "_b"}, {28'd0, bus.b}, 32'h0);
    check({tag, "_load"}, {31'd0, bus.load}, 32'h0);
    check({tag, "_valid"}, {31'd0, bus.valid}, 32'h0);
  endtask

  initial begin
    exp_t e;
    int   base;
    n_checks  = 0;
    n_errors  = 0;
    load_cnt  = 0;
    prev_load = 1'b0;
    resetn    = 1'b0;
    bus.key_n = 3'b111;
    bus.sw    = 8'h00;

    // 1: reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (3) @(posedge clk);

    // 2: clean single press with exact latency
    bus.sw = 8'h3A;
    e = '{op: 3'b110, a: 4'h3, b: 4'hA};
    exp_q.push_back(e);
    @(posedge clk);
    #1 bus.key_n = 3'b110;
    repeat (14) @(posedge clk);
    #1 check("latency_early", {31'd0, bus.load}, 32'd0);
    @(posedge clk);
    #1 check("latency_edge15", {31'd0, bus.load}, 32'd1);
    wait_loads(1, 50);
    release_all();

    // 3: bounce rejection on key 1, then held
    e = '{op: 3'b101, a: 4'h3, b: 4'hA};
    exp_q.push_back(e);
    for (int k = 0; k < 10; k++) begin
      bus.key_n = (k % 2 == 0) ? 3'b101 : 3'b111;
      repeat (2) @(posedge clk);
      #1;
    end
    check("bounce_no_load", 32'(load_cnt), 32'd1);
    bus.key_n = 3'b101;
    wait_loads(2, 50);
    release_all();

    // 4: chord of key 0 then key 2
    bus.sw = 8'h7E;
    e = '{op: 3'b010, a: 4'h7, b: 4'hE};
    exp_q.push_back(e);
    bus.key_n = 3'b110;
    repeat (3) @(posedge clk);
    #1 bus.key_n = 3'b010;
    wait_loads(3, 50);
    release_all();

    // 5: switches move while held, then re-press picks them up
    bus.sw = 8'h42;
    e = '{op: 3'b101, a: 4'h4, b: 4'h2};
    exp_q.push_back(e);
    bus.key_n = 3'b101;
    wait_loads(4, 50);
    #1 bus.sw = 8'hF1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("hold_a", {28'd0, bus.a}, 32'h4);
    check("hold_b", {28'd0, bus.b}, 32'h2);
    check("hold_no_load", 32'(load_cnt), 32'd4);
    release_all();
    e = '{op: 3'b110, a: 4'hF, b: 4'h1};
    exp_q.push_back(e);
    bus.key_n = 3'b110;
    wait_loads(5, 50);
    release_all();

    // 6: reset while collecting aborts the capture
    bus.sw = 8'h5C;
    @(posedge clk);
    #1 bus.key_n = 3'b110;
    repeat (10) @(posedge clk);
    #1;
    resetn    = 1'b0;
    bus.key_n = 3'b111;
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    base = load_cnt;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("midreset_no_load", 32'(load_cnt), 32'(base));
    check_reset_outputs("midreset_after");
    e = '{op: 3'b110, a: 4'h5, b: 4'hC};
    exp_q.push_back(e);
    @(posedge clk);
    #1 bus.key_n = 3'b110;
    wait_loads(base + 1, 50);
    release_all();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
